// File: rtl/alu_ctrl_issue.sv
// DLX decode/issue stage: decodes instructions into ALU select lines and issues them over valid/ready.
// An output register plus one-entry skid buffer keeps in_ready a plain register output.
module alu_ctrl_issue #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       out_ctl,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [31:0]      out_imm,
    output logic             out_use_imm,
    output logic             out_illegal,
    output logic [CNT_W-1:0] issue_cnt
);

    typedef struct packed {
        logic [5:0]  ctl;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        use_imm;
        logic        illegal;
    } op_t;

    localparam logic [5:0] CTL_AND  = 6'b000000;
    localparam logic [5:0] CTL_OR   = 6'b000001;
    localparam logic [5:0] CTL_XOR  = 6'b000010;
    localparam logic [5:0] CTL_PASS = 6'b000011;
    localparam logic [5:0] CTL_ADD  = 6'b100000;
    localparam logic [5:0] CTL_SUB  = 6'b100001;
    localparam logic [5:0] CTL_ADDU = 6'b100010;
    localparam logic [5:0] CTL_SUBU = 6'b100011;
    localparam logic [5:0] CTL_SLL  = 6'b101000;
    localparam logic [5:0] CTL_SRL  = 6'b101010;
    localparam logic [5:0] CTL_SRA  = 6'b101011;

    op_t dec;
    op_t out_reg, out_next, skid_reg, skid_next;
    logic out_valid_reg, out_valid_next;
    logic skid_valid_reg, skid_valid_next;
    logic in_ready_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic accept, out_fire, out_free;
    logic [15:0] imm16;
    logic [31:0] imm_sext, imm_zext;

    assign imm16    = in_instr[15:0];
    assign imm_sext = {{16{imm16[15]}}, imm16};
    assign imm_zext = {16'h0000, imm16};

    always_comb begin
        dec         = '0;
        dec.rs1     = in_instr[25:21];
        dec.illegal = 1'b0;
        if (in_instr[31:26] == 6'h00) begin
            dec.rs2 = in_instr[20:16];
            dec.rd  = in_instr[15:11];
            case (in_instr[5:0])
                6'h20: dec.ctl = CTL_ADD;
                6'h21: dec.ctl = CTL_ADDU;
                6'h22: dec.ctl = CTL_SUB;
                6'h23: dec.ctl = CTL_SUBU;
                6'h24: dec.ctl = CTL_AND;
                6'h25: dec.ctl = CTL_OR;
                6'h26: dec.ctl = CTL_XOR;
                6'h04: dec.ctl = CTL_SLL;
                6'h06: dec.ctl = CTL_SRL;
                6'h07: dec.ctl = CTL_SRA;
                6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2C, 6'h2D:
                    dec.ctl = {3'b110, in_instr[2:0] - 3'd0};
                default: dec.illegal = 1'b1;
            endcase
        end else begin
            dec.rd      = in_instr[20:16];
            dec.use_imm = 1'b1;
            dec.imm     = imm_zext;
            case (in_instr[31:26])
                6'h08: begin dec.ctl = CTL_ADD; dec.imm = imm_sext; end
                6'h09: dec.ctl = CTL_ADDU;
                6'h0A: begin dec.ctl = CTL_SUB; dec.imm = imm_sext; end
                6'h0B: dec.ctl = CTL_SUBU;
                6'h0C: dec.ctl = CTL_AND;
                6'h0D: dec.ctl = CTL_OR;
                6'h0E: dec.ctl = CTL_XOR;
                6'h0F: begin dec.ctl = CTL_PASS; dec.imm = {imm16, 16'h0000}; end
                6'h14: dec.ctl = CTL_SLL;
                6'h16: dec.ctl = CTL_SRL;
                6'h17: dec.ctl = CTL_SRA;
                default: begin
                    dec.illegal = 1'b1;
                    dec.use_imm = 1'b0;
                    dec.imm     = '0;
                end
            endcase
        end
    end

    // The skid entry is only ever filled while in_ready is high, so it is empty whenever accept is set.
    assign accept   = in_valid && in_ready_reg && !flush;
    assign out_fire = out_valid_reg && out_ready;
    assign out_free = !out_valid_reg || out_ready;

    always_comb begin
        out_next        = out_reg;
        out_valid_next  = out_valid_reg;
        skid_next       = skid_reg;
        skid_valid_next = skid_valid_reg;
        if (flush) begin
            out_valid_next  = 1'b0;
            skid_valid_next = 1'b0;
        end else if (out_free) begin
            if (skid_valid_reg) begin
                out_next        = skid_reg;
                out_valid_next  = 1'b1;
                skid_valid_next = 1'b0;
            end else if (accept) begin
                out_next       = dec;
                out_valid_next = 1'b1;
            end else begin
                out_valid_next = 1'b0;
            end
        end else if (accept) begin
            skid_next       = dec;
            skid_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_reg        <= '0;
            skid_reg       <= '0;
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
            in_ready_reg   <= 1'b1;
            cnt_reg        <= '0;
        end else begin
            out_reg        <= out_next;
            skid_reg       <= skid_next;
            out_valid_reg  <= out_valid_next;
            skid_valid_reg <= skid_valid_next;
            in_ready_reg   <= !skid_valid_next;
            if (out_fire && !out_reg.illegal && (cnt_reg != {CNT_W{1'b1}}))
                cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign in_ready    = in_ready_reg;
    assign out_valid   = out_valid_reg;
    assign out_ctl     = out_reg.ctl;
    assign out_rs1     = out_reg.rs1;
    assign out_rs2     = out_reg.rs2;
    assign out_rd      = out_reg.rd;
    assign out_imm     = out_reg.imm;
    assign out_use_imm = out_reg.use_imm;
    assign out_illegal = out_reg.illegal;
    assign issue_cnt   = cnt_reg;

endmodule
